// File: rtl/input_debouncer_pkg.sv
// Shared definitions for the input debouncer: per-channel FSM state
// encoding, default debounce length and the counter sizing helper.
package input_debouncer_pkg;

  // Two-bit state encoding; the MSB doubles as the "currently high" side.
  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    PEND_HIGH   = 2'b01,
    STABLE_HIGH = 2'b11,
    PEND_LOW    = 2'b10
  } deb_state_e;

  // Number of stable synchronized samples needed to accept a new level.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

  // Counter width able to hold 0 .. cycles-1 (cycles is at least 2).
  function automatic int count_width(input int cycles);
    return $clog2(cycles);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: two-flop synchronizer, four-state accept FSM with
// a run-length counter, registered clean level and one-cycle edge pulses.
module debounce_channel
  import input_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall
);

  localparam int CW = count_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] ONE_COUNT  = CW'(1);
  localparam logic [CW-1:0] ZERO_COUNT = {CW{1'b0}};

  logic       sync1_r;
  logic       sync2_r;
  deb_state_e state_r;
  logic [CW-1:0] count_r;

  // Bring the asynchronous raw level into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
    end
  end

  // Accept FSM: a new level is taken only after DEBOUNCE_CYCLES consecutive
  // matching samples; any opposite sample while pending drops the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= STABLE_LOW;
      count_r <= ZERO_COUNT;
      clean   <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state_r)
        STABLE_LOW: begin
          clean <= 1'b0;
          if (sync2_r) begin
            state_r <= PEND_HIGH;
            count_r <= ONE_COUNT;
          end else begin
            count_r <= ZERO_COUNT;
          end
        end
        PEND_HIGH: begin
          if (!sync2_r) begin
            state_r <= STABLE_LOW;
            count_r <= ZERO_COUNT;
          end else if (count_r == LAST_COUNT) begin
            state_r <= STABLE_HIGH;
            count_r <= ZERO_COUNT;
            clean   <= 1'b1;
            rise    <= 1'b1;
          end else begin
            count_r <= count_r + ONE_COUNT;
          end
        end
        STABLE_HIGH: begin
          clean <= 1'b1;
          if (!sync2_r) begin
            state_r <= PEND_LOW;
            count_r <= ONE_COUNT;
          end else begin
            count_r <= ZERO_COUNT;
          end
        end
        PEND_LOW: begin
          if (sync2_r) begin
            state_r <= STABLE_HIGH;
            count_r <= ZERO_COUNT;
          end else if (count_r == LAST_COUNT) begin
            state_r <= STABLE_LOW;
            count_r <= ZERO_COUNT;
            clean   <= 1'b0;
            fall    <= 1'b1;
          end else begin
            count_r <= count_r + ONE_COUNT;
          end
        end
        default: begin
          state_r <= STABLE_LOW;
          count_r <= ZERO_COUNT;
          clean   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/input_debouncer.sv
// Multi-channel input debouncer: WIDTH independent debounce channels,
// each producing a clean level plus rise/fall pulses.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] in_clean,
  output logic [WIDTH-1:0] in_rise,
  output logic [WIDTH-1:0] in_fall
);

  // One fully independent channel per input bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (raw_in[i]),
      .clean(in_clean[i]),
      .rise (in_rise[i]),
      .fall (in_fall[i])
    );
  end

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer (WIDTH=2, DEBOUNCE_CYCLES=4):
// directed table, hand-written corner sequences and random stimulus
// compared against a sliding-window reference model.
module tb_input_debouncer;

  localparam int W = 2;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] raw_in;
  logic [W-1:0] in_clean;
  logic [W-1:0] in_rise;
  logic [W-1:0] in_fall;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: two-stage sample delay, then a window of the last D
  // synchronized samples; a channel flips when all D disagree with it.
  logic [W-1:0] m_p1, m_p2, m_clean, m_rise, m_fall;
  logic [W-1:0] hist[$];

  typedef struct {
    logic [W-1:0] raw;
    logic [W-1:0] clean;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } vec_t;
  vec_t tbl[$];

  input_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw_in  (raw_in),
    .in_clean(in_clean),
    .in_rise (in_rise),
    .in_fall (in_fall)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_p1 = '0; m_p2 = '0; m_clean = '0; m_rise = '0; m_fall = '0;
    hist.delete();
  endtask

  task automatic model_edge();
    logic [W-1:0] s;
    bit all_diff;
    s = m_p2;
    m_p2 = m_p1;
    m_p1 = raw_in;
    hist.push_back(s);
    if (hist.size() > D) hist.delete(0);
    m_rise = '0;
    m_fall = '0;
    if (hist.size() == D) begin
      for (int ch = 0; ch < W; ch++) begin
        all_diff = 1'b1;
        for (int k = 0; k < D; k++)
          if (hist[k][ch] == m_clean[ch]) all_diff = 1'b0;
        if (all_diff) begin
          m_clean[ch] = ~m_clean[ch];
          if (m_clean[ch]) m_rise[ch] = 1'b1;
          else             m_fall[ch] = 1'b1;
        end
      end
    end
  endtask

  // Apply one raw value for one clock edge, then compare against the model.
  task automatic tick(input logic [W-1:0] r);
    raw_in = r;
    @(posedge clk);
    model_edge();
    #1;
    check("model_clean", in_clean, m_clean);
    check("model_rise", in_rise, m_rise);
    check("model_fall", in_fall, m_fall);
  endtask

  task automatic apply_reset(input int cycles);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_clean", in_clean, 0);
    check("rst_pulses", {in_rise, in_fall}, 0);
    for (int c = 0; c < cycles; c++) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic add(input logic [W-1:0] r, input logic [W-1:0] c,
                     input logic [W-1:0] ri, input logic [W-1:0] f);
    vec_t v;
    v.raw = r; v.clean = c; v.rise = ri; v.fall = f;
    tbl.push_back(v);
  endtask

  initial begin
    int rises;
    logic [W-1:0] r;

    rst_n  = 1'b0;
    raw_in = '0;
    model_reset();
    @(posedge clk);
    #1;
    check("init_clean", in_clean, 0);
    check("init_pulses", {in_rise, in_fall}, 0);
    rst_n = 1'b1;

    // Directed table: channel 0 up, channel 1 up, then both down together.
    add(2'b01, 2'b00, 2'b00, 2'b00); add(2'b01, 2'b00, 2'b00, 2'b00);
    add(2'b01, 2'b00, 2'b00, 2'b00); add(2'b01, 2'b00, 2'b00, 2'b00);
    add(2'b01, 2'b00, 2'b00, 2'b00); add(2'b01, 2'b01, 2'b01, 2'b00);
    add(2'b01, 2'b01, 2'b00, 2'b00);
    add(2'b11, 2'b01, 2'b00, 2'b00); add(2'b11, 2'b01, 2'b00, 2'b00);
    add(2'b11, 2'b01, 2'b00, 2'b00); add(2'b11, 2'b01, 2'b00, 2'b00);
    add(2'b11, 2'b01, 2'b00, 2'b00); add(2'b11, 2'b11, 2'b10, 2'b00);
    add(2'b11, 2'b11, 2'b00, 2'b00);
    add(2'b00, 2'b11, 2'b00, 2'b00); add(2'b00, 2'b11, 2'b00, 2'b00);
    add(2'b00, 2'b11, 2'b00, 2'b00); add(2'b00, 2'b11, 2'b00, 2'b00);
    add(2'b00, 2'b11, 2'b00, 2'b00); add(2'b00, 2'b00, 2'b00, 2'b11);
    add(2'b00, 2'b00, 2'b00, 2'b00);
    for (int i = 0; i < tbl.size(); i++) begin
      tick(tbl[i].raw);
      check("tbl_clean", in_clean, tbl[i].clean);
      check("tbl_rise", in_rise, tbl[i].rise);
      check("tbl_fall", in_fall, tbl[i].fall);
    end

    // Short 3-cycle glitch on channel 0 must never be accepted.
    for (int i = 0; i < 11; i++) begin
      tick((i < 3) ? 2'b01 : 2'b00);
      check("glitch_quiet", {in_clean, in_rise}, 0);
    end

    // Broken run 1,1,0,1,1,1,1: single rise, only after the last four 1s.
    rises = 0;
    for (int i = 0; i < 14; i++) begin
      tick((i == 2) ? 2'b00 : 2'b01);
      if (in_rise[0]) rises++;
      if (i == 7) check("broken_run_early", in_clean, 2'b00);
      if (i == 8) check("broken_run_rise", {in_clean, in_rise}, 4'b0101);
    end
    check("broken_run_count", rises, 1);
    for (int i = 0; i < 8; i++) tick(2'b00);

    // Both channels step together: simultaneous rise, then simultaneous fall.
    for (int i = 0; i < 7; i++) begin
      tick(2'b11);
      if (i == 4) check("both_early", in_clean, 2'b00);
      if (i == 5) check("both_rise", {in_clean, in_rise}, 4'b1111);
    end
    for (int i = 0; i < 7; i++) begin
      tick(2'b00);
      if (i == 5) check("both_fall", {in_clean, in_fall}, 4'b0011);
    end

    // Reset while channel 1 is pending: no pulse, full latency afterwards.
    tick(2'b10);
    tick(2'b10);
    apply_reset(2);
    for (int i = 0; i < 6; i++) begin
      tick(2'b10);
      if (i < 5) check("rst_pend_quiet", {in_clean, in_rise, in_fall}, 0);
      else       check("rst_pend_accept", {in_clean, in_rise}, 4'b1010);
    end
    for (int i = 0; i < 8; i++) tick(2'b00);

    // Random bouncing inputs with occasional resets against the model.
    r = '0;
    for (int n = 0; n < 800; n++) begin
      for (int b = 0; b < W; b++)
        if ($urandom_range(5) == 0) r[b] = ~r[b];
      if ($urandom_range(299) == 0) apply_reset($urandom_range(1, 3));
      tick(r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 Parameter WIDTH, default 2: number of independent raw input channels, matching the 2-bit vector input of the downstream gate stage.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized samples required to accept a new level; legal range 2..65535; the board build overrides it.
REQ-003 CLK  input  1  single system clock; all state updates on rising edge.
REQ-004 RST_N  input  1  asynchronous, active-low reset.
REQ-005 RAW_IN  input  WIDTH  asynchronous, bouncing switch/button levels.
REQ-006 IN_CLEAN  output  WIDTH  debounced level per channel, registered; drives the gate stage vector input.
REQ-007 IN_RISE  output  WIDTH  one-cycle pulse when IN_CLEAN[i] goes 0->1.
REQ-008 IN_FALL  output  WIDTH  one-cycle pulse when IN_CLEAN[i] goes 1->0.

Function
REQ-009 Each channel SHALL pass RAW_IN[i] through a two-flop synchronizer; the second flop output is sample S[i].
REQ-010 Each channel SHALL run a 4-state FSM: STABLE_LOW, PEND_HIGH, STABLE_HIGH, PEND_LOW.
REQ-011 STABLE_LOW: S=1 -> PEND_HIGH with count=1; S=0 -> stay, count=0.
REQ-012 PEND_HIGH: S=0 -> STABLE_LOW, count=0, no output change; S=1 and count=DEBOUNCE_CYCLES-1 -> STABLE_HIGH, IN_CLEAN[i]<=1, IN_RISE[i]<=1; otherwise count+1.
REQ-013 STABLE_HIGH and PEND_LOW SHALL mirror REQ-011/012 with polarity inverted; the accepting transition sets IN_CLEAN[i]<=0, IN_FALL[i]<=1.
REQ-014 Latency: a clean RAW_IN step SHALL change IN_CLEAN on the (DEBOUNCE_CYCLES+2)th rising edge, counting the first edge that samples the new level as edge 1.
REQ-015 Any opposite-level sample during a pending state SHALL discard the partial count; no saturation or hysteresis beyond this.
REQ-016 IN_RISE/IN_FALL SHALL be high for exactly one cycle and never high simultaneously on one channel.
REQ-017 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each follow their own FSM with no interaction.
REQ-018 Counter width SHALL be clog2(DEBOUNCE_CYCLES) bits; count SHALL never exceed DEBOUNCE_CYCLES-1 (no wrap).

Reset
REQ-019 RST_N low SHALL asynchronously clear synchronizer flops, counters, IN_CLEAN, IN_RISE, IN_FALL to 0 and force STABLE_LOW.
REQ-020 Reset asserted mid-pending SHALL abandon the pending transition with no pulse; after release, a held-high input SHALL be accepted after a full REQ-014 latency.
REQ-021 No pulse SHALL be generated by reset assertion or release alone.

Structure
REQ-022 A shared package SHALL hold the FSM state encoding (2-bit, STABLE_LOW=00, PEND_HIGH=01, STABLE_HIGH=11, PEND_LOW=10) and the default DEBOUNCE_CYCLES constant.
REQ-023 Per-channel logic SHALL be a sub-module debounce_channel (synchronizer, FSM, counter, pulse regs), instantiated WIDTH times by a generate loop in input_debouncer.

Verification (DEBOUNCE_CYCLES=4)
REQ-024 RAW_IN 00->01 held -> IN_CLEAN=01 and IN_RISE=01 for one cycle at edge 6; IN_CLEAN[1] stays 0.
REQ-025 RAW_IN[0] high for 3 cycles then low -> IN_CLEAN, IN_RISE remain 0 throughout.
REQ-026 RAW_IN[0] pattern 1,1,0,1,1,1,1 (one per cycle) -> IN_CLEAN[0] rises only after the last four 1s plus sync delay, single IN_RISE pulse.
REQ-027 RAW_IN 00->11 same cycle, later 11->00 -> both channels rise on same edge, later both IN_FALL pulse on same edge, IN_CLEAN=00.
REQ-028 RST_N pulsed low two cycles after RAW_IN[1] rises -> outputs 00 immediately, no pulse; after release with RAW_IN held 10, IN_CLEAN=10 six edges after release.
